// File: rtl/stream_packer_if.sv
// stream_packer_if: upstream word/flush handshake and downstream packed-beat handshake.
interface stream_packer_if #(
   parameter int SIZEDATA = 32,
   parameter int RATIO    = 4,
   parameter int BITSCONT = $clog2(RATIO) + 1
);
   logic                      valid_i;
   logic [SIZEDATA-1:0]       data_i;
   logic                      ready_o;
   logic                      flush_i;
   logic                      valid_o;
   logic [SIZEDATA*RATIO-1:0] data_o;
   logic [BITSCONT-1:0]       words_o;
   logic                      ready_i;
   modport slave (input valid_i, data_i, flush_i, ready_i, output ready_o, valid_o, data_o, words_o);
   modport master (output valid_i, data_i, flush_i, ready_i, input ready_o, valid_o, data_o, words_o);
endinterface

// File: rtl/stream_packer.sv
// stream_packer: packs RATIO input words into one wide beat; flush closes a partial beat zero-padded.
module stream_packer #(
   parameter int SIZEDATA = 32,
   parameter int RATIO    = 4,
   parameter int BITSCONT = $clog2(RATIO) + 1
) (
   input logic          clk_i,
   input logic          rst_i,
   stream_packer_if.slave s
);
   typedef enum logic {FILL, FULL} state_t;
   state_t                    state_q, state_d;
   logic [BITSCONT-1:0]       cnt_q, cnt_d, cnt_w;
   logic [SIZEDATA*RATIO-1:0] data_q, data_d;
   logic                      acc, oxfer;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= FILL;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end
   always_comb begin
      acc     = s.valid_i && s.ready_o;
      oxfer   = s.valid_o && s.ready_i;
      cnt_w   = cnt_q + BITSCONT'(acc);
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      if (state_q == FILL) begin
         if (acc) data_d[cnt_q*SIZEDATA +: SIZEDATA] = s.data_i;
         cnt_d   = cnt_w;
         state_d = (cnt_w == BITSCONT'(RATIO) || (s.flush_i && cnt_w != '0)) ? FULL : FILL;
      end else if (oxfer) begin
         // a word accepted on the draining edge starts the next beat in lane 0
         data_d = '0;
         if (acc) data_d[SIZEDATA-1:0] = s.data_i;
         cnt_d   = BITSCONT'(acc);
         state_d = FILL;
      end
   end
   always_comb begin
      s.valid_o = state_q == FULL;
      s.ready_o = !rst_i && (state_q == FILL || s.ready_i);
      s.words_o = cnt_q;
      s.data_o  = data_q;
   end
endmodule

// File: tb/tb_stream_packer.sv
// tb_stream_packer: directed and random stimulus with a beat scoreboard checked by a separate monitor.
module tb_stream_packer;
   localparam int SD = 32;
   localparam int R  = 4;
   localparam int BC = $clog2(R) + 1;
   localparam int W  = SD * R;
   typedef struct {
      logic [W-1:0]  data;
      logic [BC-1:0] words;
   } beat_t;
   logic clk = 0;
   logic rst = 0;
   always #5 clk = ~clk;
   stream_packer_if #(.SIZEDATA(SD), .RATIO(R), .BITSCONT(BC)) bus ();
   stream_packer #(.SIZEDATA(SD), .RATIO(R), .BITSCONT(BC)) dut (.clk_i(clk), .rst_i(rst), .s(bus));
   beat_t         exp_q[$];
   int            checks = 0;
   int            errors = 0;
   logic [W-1:0]  buf_m = '0;
   logic [W-1:0]  cur_data;
   logic [BC-1:0] cur_words;
   int            n_m = 0;
   bit            full_m = 0;

   task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // drive one cycle; the model decides acceptance, beat closure and draining
   task automatic step(input bit v, input logic [SD-1:0] d, input bit f, input bit r, output bit acc);
      bit    full_b;
      beat_t b;
      bus.valid_i = v;
      bus.data_i  = d;
      bus.flush_i = f;
      bus.ready_i = r;
      @(negedge clk);
      full_b = full_m;
      chk("ready_o", bus.ready_o, !full_b || r);
      chk("valid_o", bus.valid_o, full_b);
      if (full_b) begin
         chk("hold_data", bus.data_o, cur_data);
         chk("hold_words", bus.words_o, cur_words);
      end
      acc = v && (!full_b || r);
      if (acc) begin
         buf_m[n_m*SD +: SD] = d;
         n_m++;
      end
      if (!full_b && (n_m == R || (f && n_m > 0))) begin
         cur_data  = buf_m;
         cur_words = BC'(n_m);
         b.data    = buf_m;
         b.words   = BC'(n_m);
         exp_q.push_back(b);
         buf_m  = '0;
         n_m    = 0;
         full_m = 1;
      end else if (full_b && r) full_m = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic st(input bit v, input logic [SD-1:0] d, input bit f = 0, input bit r = 1);
      bit a;
      step(v, d, f, r, a);
   endtask

   task automatic do_reset();
      rst = 1;
      bus.valid_i = 0;
      bus.data_i  = '0;
      bus.flush_i = 0;
      bus.ready_i = 0;
      #1;
      chk("rst_ready_o", bus.ready_o, 0);
      chk("rst_valid_o", bus.valid_o, 0);
      chk("rst_data_o", bus.data_o, 0);
      chk("rst_words_o", bus.words_o, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 0;
      buf_m  = '0;
      n_m    = 0;
      full_m = 0;
      exp_q.delete();
   endtask

   always @(negedge clk) begin
      beat_t b;
      if (!rst && bus.valid_o && bus.ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat_unexpected: got %h expected none", bus.data_o);
         end else begin
            b = exp_q.pop_front();
            chk("beat_data", bus.data_o, b.data);
            chk("beat_words", bus.words_o, b.words);
         end
      end
   end

   initial begin
      int  nw, cyc;
      bit  a;
      do_reset();
      for (int i = 1; i <= 4; i++) st(1, SD'(i));
      chk("full_data", bus.data_o, 128'h00000004_00000003_00000002_00000001);
      chk("full_words", bus.words_o, 4);
      st(0, 0);
      for (int i = 0; i < 4; i++) st(1, SD'('h21 + i));
      for (int i = 0; i < 5; i++) st(1, 'hBAD, 0, 0);
      chk("stall_data", bus.data_o, 128'h00000024_00000023_00000022_00000021);
      st(0, 0);
      st(0, 0);
      for (int i = 0; i < 4; i++) st(1, SD'('h31 + i));
      st(1, 'hA);
      chk("overlap_data", bus.data_o, 128'hA);
      chk("overlap_words", bus.words_o, 1);
      st(1, 'hB);
      st(1, 'hC);
      st(1, 'hD, 1, 0);
      st(0, 0, 1, 0);
      st(1, 'hE, 1, 1);
      st(0, 0, 1, 1);
      st(1, 'h11);
      st(1, 'h22);
      st(0, 0, 1);
      chk("flush_data", bus.data_o, 128'h00000000_00000000_00000022_00000011);
      chk("flush_words", bus.words_o, 2);
      st(0, 0);
      st(1, 'h55);
      st(1, 'h66, 1, 0);
      chk("flush_acc_words", bus.words_o, 2);
      st(0, 0);
      st(0, 0, 1);
      st(1, 'h11);
      st(1, 'h22);
      do_reset();
      for (int i = 5; i <= 8; i++) st(1, SD'(i));
      chk("after_rst_data", bus.data_o, 128'h00000008_00000007_00000006_00000005);
      chk("after_rst_words", bus.words_o, 4);
      st(0, 0);
      nw  = 0;
      cyc = 0;
      while (nw < 1000 && cyc < 20000) begin
         step($urandom_range(0, 3) != 0, SD'(nw + 1), $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, a);
         if (a) nw++;
         cyc++;
      end
      if (nw < 1000) begin
         checks++;
         errors++;
         $display("FAIL random_timeout: got %0d words expected 1000", nw);
      end
      for (int i = 0; i < 4; i++) st(0, 0, 1, 1);
      chk("queue_empty", W'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
